// File: rtl/ram_readout_seq.sv
// Streams count consecutive words out of a synchronous RAM onto a valid/ready port.
// Reads are credit-limited so the FWFT output buffer can never overflow.
module ram_readout_seq #(
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              RE,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              ram_e,
  output logic              ram_r,
  output logic              ram_w,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_o,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2 ** ADDR_W);
  localparam logic [OCC_W:0]   DEPTH_C = (OCC_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  accepted_q, accepted_d;
  // [0]: read presented to the RAM this cycle, [1]: its data is on ram_o this cycle
  logic [1:0]        vld_pipe_q, vld_pipe_d;
  logic              done_q, done_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic             push, pop, issue;
  logic [OCC_W:0]   credit_used;

  assign push        = vld_pipe_q[1];
  assign pop         = (occ_q != '0) && dout_ready;
  // Both pipeline slots already own a FIFO entry, so they count against the credit.
  assign credit_used = {1'b0, occ_q} + (OCC_W + 1)'(vld_pipe_q[0]) + (OCC_W + 1)'(vld_pipe_q[1]);
  assign issue       = (state_q == READ) && (issued_q != count_q) && (credit_used < DEPTH_C);

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    ram_addr_d  = ram_addr_q;
    count_d     = count_q;
    issued_d    = issued_q;
    accepted_d  = accepted_q;
    vld_pipe_d  = {vld_pipe_q[0], issue};
    done_d      = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q + OCC_W'(push) - OCC_W'(pop);

    if (issue) begin
      ram_addr_d  = next_addr_q;
      next_addr_d = next_addr_q + 1'b1;
      issued_d    = issued_q + 1'b1;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      accepted_d = accepted_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            count_d     = (count > MAX_CNT) ? MAX_CNT : count;
            next_addr_d = base_addr;
            issued_d    = '0;
            accepted_d  = '0;
            state_d     = READ;
          end
        end
      end
      READ:  if (issued_d == count_q) state_d = DRAIN;
      DRAIN: begin
        if (accepted_d == count_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RE) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      ram_addr_q  <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      vld_pipe_q  <= '0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      ram_addr_q  <= ram_addr_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      accepted_q  <= accepted_d;
      vld_pipe_q  <= vld_pipe_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
    end
  end

  // Storage needs no reset; an empty buffer is masked on dout.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ram_o;
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign ram_e      = vld_pipe_q[0];
  assign ram_r      = vld_pipe_q[0];
  assign ram_w      = 1'b0;
  assign ram_addr   = ram_addr_q;
  assign dout_valid = (occ_q != '0);
  assign dout       = dout_valid ? mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_ram_readout_seq.sv
// Random and directed bench for ram_readout_seq against a queue-based transfer model.
module tb_ram_readout_seq;
  localparam int DW = 24, AW = 9, DEPTH = 4;

  logic          clk = 1'b0;
  logic          RE, start, dout_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          busy, done, ram_e, ram_r, ram_w, dout_valid;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_o = '0, dout;

  ram_readout_seq #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .RE(RE), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .ram_e(ram_e), .ram_r(ram_r), .ram_w(ram_w),
    .ram_addr(ram_addr), .ram_o(ram_o), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Synchronous RAM model; junk on ram_o whenever no read was made.
  logic [DW-1:0] ram_mem [2**AW];
  always @(posedge clk) ram_o <= ram_e ? ram_mem[ram_addr] : DW'($urandom);

  // Consumer: 0 = always ready, 1 = random, 2 = stalled
  int rdy_mode = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = 1'($urandom_range(0, 1));
      default: dout_ready = 1'b0;
    endcase
  end

  // Transfer model: expected address and word queues, handshake counters.
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  logic [DW-1:0] acc_log  [$];
  int            acc_cyc  [$];
  logic [AW-1:0] addr_log [$];
  bit            m_busy = 0, m_done = 0, hold_chk = 0;
  int            m_cnt = 0, n_iss = 0, n_acc = 0, cyc = 0, done_cnt = 0;
  logic [DW-1:0] held;

  always @(negedge clk) begin
    bit acc;
    int c;
    cyc++;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("ram_r_eq_ram_e", ram_r, ram_e);
    chk("ram_w", ram_w, 0);
    if (ram_e) begin
      if (exp_addr.size() == 0) chk("spurious_read", 1, 0);
      else chk("ram_addr", ram_addr, exp_addr.pop_front());
      addr_log.push_back(ram_addr);
      n_iss++;
    end
    if (n_iss - n_acc > DEPTH) chk("outstanding", n_iss - n_acc, DEPTH);
    if (dout_valid && exp_data.size() == 0) chk("spurious_dout", 1, 0);
    if (hold_chk) begin
      chk("hold_valid", dout_valid, 1);
      chk("hold_data", dout, held);
    end
    acc = dout_valid && dout_ready;
    if (acc && exp_data.size() > 0) begin
      chk("dout", dout, exp_data.pop_front());
      acc_log.push_back(dout);
      acc_cyc.push_back(cyc);
      n_acc++;
    end
    hold_chk = dout_valid && !dout_ready && !RE;
    held     = dout;
    if (done) done_cnt++;
    m_done = 0;
    if (RE) begin
      m_busy = 0; hold_chk = 0; n_iss = 0; n_acc = 0;
      exp_addr.delete(); exp_data.delete();
    end else if (m_busy) begin
      if (acc && n_acc == m_cnt) begin
        m_busy = 0; m_done = 1;
        chk("issued_all", n_iss, m_cnt);
      end
    end else if (start) begin
      c = (count > 512) ? 512 : int'(count);
      if (c == 0) m_done = 1;
      else begin
        m_busy = 1; m_cnt = c; n_iss = 0; n_acc = 0;
        for (int i = 0; i < c; i++) begin
          exp_addr.push_back(AW'((int'(base_addr) + i) % 512));
          exp_data.push_back(ram_mem[(int'(base_addr) + i) % 512]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_xfer(input int b, input int c);
    start = 1'b1; base_addr = AW'(b); count = (AW + 1)'(c);
    tick(1);
    start = 1'b0; base_addr = AW'($urandom); count = (AW + 1)'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin tick(1); k++; end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ram_e"}, ram_e, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_dout"}, dout, 0);
  endtask

  initial begin
    int k, d0;
    for (int i = 0; i < 2**AW; i++) ram_mem[i] = DW'($urandom);
    RE = 1'b1; start = 1'b0; base_addr = '0; count = '0; dout_ready = 1'b1;
    tick(2);
    chk_idle("reset");
    RE = 1'b0;
    tick(1);

    // Basic stream with literal expectations
    for (int i = 0; i < 4; i++) ram_mem[10 + i] = DW'(24'h11 + i);
    acc_log.delete(); acc_cyc.delete(); d0 = done_cnt;
    start_xfer(10, 4);
    chk("t2_busy_after_start", busy, 1);
    chk("t2_ram_e_first_cycle", ram_e, 0);
    tick(1);
    chk("t2_ram_e_latency", ram_e, 1);
    chk("t2_first_addr", ram_addr, 10);
    wait_done(50);
    tick(2);
    chk("t2_words", acc_log.size(), 4);
    if (acc_log.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t2_word", acc_log[i], 24'h11 + i);
        chk("t2_back_to_back", acc_cyc[i], acc_cyc[0] + i);
      end
    chk("t2_done_pulses", done_cnt - d0, 1);

    // Address wrap
    addr_log.delete();
    start_xfer(510, 4);
    wait_done(50);
    tick(1);
    chk("t3_reads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("t3_a0", addr_log[0], 510); chk("t3_a1", addr_log[1], 511);
      chk("t3_a2", addr_log[2], 0);   chk("t3_a3", addr_log[3], 1);
    end

    // Backpressure: only the credit's worth of reads while stalled
    rdy_mode = 2;
    start_xfer(int'($urandom_range(0, 511)), 8);
    tick(5);
    chk("t4_reads_while_stalled", n_iss, DEPTH);
    chk("t4_valid_while_stalled", dout_valid, 1);
    rdy_mode = 0;
    wait_done(100);
    tick(1);

    // count=0 and start while busy
    start_xfer(int'($urandom_range(0, 511)), 0);
    chk("t5_done_zero", done, 1);
    chk("t5_busy_zero", busy, 0);
    chk("t5_no_read", ram_e, 0);
    tick(1);
    chk("t5_done_single", done, 0);
    chk("t5_no_read2", ram_e, 0);
    rdy_mode = 1; d0 = done_cnt;
    start_xfer(100, 6);
    tick(2);
    start = 1'b1; base_addr = AW'(300); count = (AW + 1)'(3);
    tick(1);
    start = 1'b0;
    wait_done(200);
    tick(2);
    chk("t5_one_done", done_cnt - d0, 1);

    // Reset in the middle of random traffic
    start_xfer(int'($urandom_range(0, 511)), int'($urandom_range(5, 40)));
    tick(int'($urandom_range(3, 15)));
    RE = 1'b1;
    tick(2);
    chk_idle("t1");
    RE = 1'b0;
    tick(1);

    // Abort after 3 of 8 words, then a clean transfer
    rdy_mode = 0;
    start_xfer(200, 8);
    k = 0;
    while (n_acc < 3 && k < 50) begin tick(1); k++; end
    chk("t6_reached_3", n_acc >= 3, 1);
    d0 = done_cnt;
    RE = 1'b1;
    tick(1);
    RE = 1'b0;
    tick(3);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_empty", dout_valid, 0);
    acc_log.delete();
    start_xfer(0, 2);
    wait_done(50);
    tick(1);
    chk("t6_words", acc_log.size(), 2);

    // count clamp
    start_xfer(int'($urandom_range(0, 511)), 700);
    wait_done(700);
    tick(1);

    // Random transfers
    rdy_mode = 1;
    for (int t = 0; t < 15; t++) begin
      start_xfer(int'($urandom_range(0, 511)), int'($urandom_range(1, 40)));
      wait_done(1000);
      tick(int'($urandom_range(0, 3)));
    end
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
